down_counter: RTL
=================

# down_counter

Loadable down counter that walks from HIGH to LOW (default 10 down to 3) and then wraps to HIGH. It is the counting-down counterpart to the team's 3-to-10 up counter. It is used where a sequence must be consumed in reverse, e.g. countdown timers and descending slot indices. It adds count enable, range-checked load, a wrap pulse, a wrap tally and an optional one-shot mode.

## Interface
- WIDTH, 4, counter width in bits
- HIGH, 10, start/wrap value; must satisfy LOW < HIGH <= 2^WIDTH-1
- LOW, 3, terminal value
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low
- en  input  1  count enable; decrement on clk edge when high
- load  input  1  synchronous load strobe; priority over en
- data  input  WIDTH  load value
- count  output  WIDTH  current counter value (registered)
- tc  output  1  one-cycle wrap pulse (registered)
- wraps  output  8  number of wraps, modulo 256 (registered)
- load_err  output  1  one-cycle pulse: last load value was out of range (registered)
- done  output  1  one-shot completion flag; constant 0 unless DNCNT_ONESHOT_EN

## Operation
- Reset (rst_n=0, asynchronous, any time): count=HIGH, tc=0, wraps=0, load_err=0, done=0.
- Priority per edge: load > en > hold.
- load=1, LOW<=data<=HIGH: count<=data, load_err<=0, done<=0.
- load=1, data<LOW or data>HIGH: count<=HIGH (clamp to start), load_err<=1, done<=0.
- load=0, en=1, count>LOW: count<=count-1.
- load=0, en=1, count==LOW: count<=HIGH, wraps<=wraps+1 (8-bit, 255 rolls to 0), tc<=1.
- load=0, en=0: count, wraps and done hold.
- tc and load_err are 0 on every edge where their set condition is absent, so they last exactly one cycle.
- A load on the same edge as a would-be wrap suppresses the wrap: no tc, no wraps increment.
- Counter never holds a value outside [LOW,HIGH] after reset or load.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- count changes one edge after en/load sampled high.
- tc is high in the cycle where count first shows HIGH after a wrap, coincident with the new wraps value.
- load_err is high in the cycle where the clamped count=HIGH is first visible.
- Full cycle with en held high: HIGH-LOW+1 edges (8 for defaults). tc period is 8 cycles.
- rst_n deassertion must be synchronous to clk externally; the first counting edge is the first rising clk with rst_n=1.

## Configuration
- DNCNT_ONESHOT_EN defined:
  - At count==LOW with en=1 and load=0, count holds at LOW and done<=1 (sticky).
  - tc is not pulsed and wraps is not incremented.
  - done clears only on load or reset.
- DNCNT_ONESHOT_EN undefined: free-running wrap as described above; done tied to 0.

## Test plan
- Reset then en=1 for 9 cycles -> count 10,9,8,7,6,5,4,3,10; tc high only with the final 10; wraps=1.
- load=1, data=6 while en=1 -> count=6 next cycle, then 5. load=1, data=12 -> count=10, load_err=1 for one cycle. Same check with data=2.
- Assert load data=7 on the edge where count==3 and en=1 -> count=7, tc=0, wraps unchanged.
- en toggled 1,0,0,1 from count=10 -> 9,9,9,8. Pull rst_n low mid-count at count=5, asynchronously between edges -> count=10, wraps=0 immediately.
- Run 256 wraps -> wraps returns to 0; tc pulses every 8 cycles.
- With DNCNT_ONESHOT_EN: en=1 from reset for 12 cycles -> count stops at 3, done=1, tc never high, wraps=0; load data=9 -> done=0, count=9.

Source files
------------

// File: rtl/down_counter.sv
// Loadable down counter HIGH..LOW with wrap pulse, wrap tally and range-checked load.
// Latency: every output is registered and updates one clk edge after load/en are sampled.
// Backpressure: none; en gates counting, load takes priority over en. Optional DNCNT_ONESHOT_EN stops at LOW and raises sticky done.
module down_counter #(
    parameter int WIDTH = 4,
    parameter int HIGH  = 10,
    parameter int LOW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic [7:0]       wraps,
    output logic             load_err,
    output logic             done
);

    localparam logic [WIDTH-1:0] HI = WIDTH'(HIGH);
    localparam logic [WIDTH-1:0] LO = WIDTH'(LOW);

    // A load value is accepted only inside the counting range; anything else clamps to HI.
    logic data_ok;
    // The counter sits on its terminal value; the next enabled edge wraps (or stops in one-shot).
    logic at_low;
    // An enabled, non-loading edge at LOW.
    logic wrap_now;

    assign data_ok  = (data >= LO) && (data <= HI);
    assign at_low   = (count == LO);
    assign wrap_now = !load && en && at_low;

    // Counter value: load beats enable; at LOW either wrap to HI or, in one-shot, hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= HI;
        end else if (load) begin
            count <= data_ok ? data : HI;
        end else if (en) begin
            if (!at_low) begin
                count <= count - 1'b1;
            end else begin
`ifdef DNCNT_ONESHOT_EN
                count <= LO;
`else
                count <= HI;
`endif
            end
        end
    end

    // Wrap pulse and wrap tally; a load on the same edge suppresses both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc    <= 1'b0;
            wraps <= 8'd0;
        end else begin
`ifdef DNCNT_ONESHOT_EN
            tc    <= 1'b0;
            wraps <= wraps;
`else
            tc    <= wrap_now;
            if (wrap_now) begin
                wraps <= wraps + 8'd1;
            end
`endif
        end
    end

    // Out-of-range load flag, high for exactly the cycle the clamped HI first shows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_err <= 1'b0;
        end else begin
            load_err <= load && !data_ok;
        end
    end

`ifdef DNCNT_ONESHOT_EN
    // Sticky completion flag: set when an enabled edge finds LOW, cleared only by load or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else if (load) begin
            done <= 1'b0;
        end else if (wrap_now) begin
            done <= 1'b1;
        end
    end
`else
    // Free-running build never completes.
    assign done = 1'b0;
`endif

endmodule
